// File: rtl/dvi_timing_gen_pkg.sv
// Shared 800x600@60 raster constants, pixel type and sequencer state encoding.
package dvi_timing_pkg;

    localparam int H_ACTIVE = 800;
    localparam int H_FP     = 40;
    localparam int H_SYNC   = 128;
    localparam int H_BP     = 88;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 600;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 4;
    localparam int V_BP     = 23;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam bit SYNC_POL = 1'b1;

    typedef logic [23:0] pixel_t;

    typedef enum logic {
        SYNCING = 1'b0,
        RUNNING = 1'b1
    } state_t;

endpackage

// File: rtl/dvi_timing_gen_if.sv
// Upstream pixel stream handshake: source drives Video/VideoValid, sink returns VideoReady.
interface dvi_timing_gen_if;
    import dvi_timing_pkg::*;

    pixel_t Video;
    logic   VideoValid;
    logic   VideoReady;

    modport master (output Video, output VideoValid, input VideoReady);
    modport slave  (input Video, input VideoValid, output VideoReady);

endinterface

// File: rtl/dvi_timing_gen_raster_counter.sv
// Free-running hcnt/vcnt raster position with active/sync window decode and frame strobes.
// Decodes are combinational from the counter registers; they never stall.
module raster_counter
#(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23
)
(
    input  logic clock,
    input  logic reset,
    output logic active,
    output logic hsyncOn,
    output logic vsyncOn,
    output logic frameEnd,
    output logic frameTop
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          lineEnd;
    logic          lastLine;

    assign lineEnd  = int'(hcnt) == H_TOTAL - 1;
    assign lastLine = int'(vcnt) == V_TOTAL - 1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (lineEnd) begin
            hcnt <= '0;
            vcnt <= lastLine ? '0 : vcnt + VW'(1);
        end else begin
            hcnt <= hcnt + HW'(1);
        end
    end

    assign active   = (int'(hcnt) < H_ACTIVE) && (int'(vcnt) < V_ACTIVE);
    assign hsyncOn  = (int'(hcnt) >= H_ACTIVE + H_FP) && (int'(hcnt) < H_ACTIVE + H_FP + H_SYNC);
    // vsync spans whole lines, so it only looks at vcnt and flips on the hcnt=0 boundary.
    assign vsyncOn  = (int'(vcnt) >= V_ACTIVE + V_FP) && (int'(vcnt) < V_ACTIVE + V_FP + V_SYNC);
    assign frameEnd = lineEnd && lastLine;
    assign frameTop = (hcnt == '0) && (vcnt == '0);

endmodule

// File: rtl/dvi_timing_gen.sv
// DVI raster generator: pulls one upstream pixel per active cycle, emits registered RGB/DE/syncs.
// Outputs lag the counter position by one clock; raster never stalls, missing pixels flag underflow.
module dvi_timing_gen
    import dvi_timing_pkg::*;
#(
    parameter int H_ACTIVE = dvi_timing_pkg::H_ACTIVE,
    parameter int H_FP     = dvi_timing_pkg::H_FP,
    parameter int H_SYNC   = dvi_timing_pkg::H_SYNC,
    parameter int H_BP     = dvi_timing_pkg::H_BP,
    parameter int V_ACTIVE = dvi_timing_pkg::V_ACTIVE,
    parameter int V_FP     = dvi_timing_pkg::V_FP,
    parameter int V_SYNC   = dvi_timing_pkg::V_SYNC,
    parameter int V_BP     = dvi_timing_pkg::V_BP,
    parameter bit SYNC_POL = dvi_timing_pkg::SYNC_POL
)
(
    input  logic                   clock,
    input  logic                   reset,
    dvi_timing_gen_if.slave        vid,
    output pixel_t                 dvi_rgb,
    output logic                   dvi_de,
    output logic                   dvi_hsync,
    output logic                   dvi_vsync,
    output logic                   underflow,
    output logic                   frame_start
);

    state_t state;
    logic   active;
    logic   hsyncOn;
    logic   vsyncOn;
    logic   frameEnd;
    logic   frameTop;
    logic   pixelSlot;

    raster_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) uRaster (
        .clock    (clock),
        .reset    (reset),
        .active   (active),
        .hsyncOn  (hsyncOn),
        .vsyncOn  (vsyncOn),
        .frameEnd (frameEnd),
        .frameTop (frameTop)
    );

    // Pixels are only pulled once aligned to a frame top, so upstream pixel 0 lands at (0,0).
    assign pixelSlot      = (state == RUNNING) && active;
    assign vid.VideoReady = pixelSlot;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= SYNCING;
            dvi_rgb     <= '0;
            dvi_de      <= 1'b0;
            dvi_hsync   <= ~SYNC_POL;
            dvi_vsync   <= ~SYNC_POL;
            underflow   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            case (state)
                SYNCING: if (frameEnd) state <= RUNNING;
                RUNNING: state <= RUNNING;
                default: state <= SYNCING;
            endcase
            dvi_rgb     <= (pixelSlot && vid.VideoValid) ? vid.Video : '0;
            dvi_de      <= pixelSlot;
            dvi_hsync   <= hsyncOn ? SYNC_POL : ~SYNC_POL;
            dvi_vsync   <= vsyncOn ? SYNC_POL : ~SYNC_POL;
            underflow   <= underflow | (pixelSlot && !vid.VideoValid);
            frame_start <= (state == RUNNING) && frameTop;
        end
    end

endmodule
